// File: rtl/avalon_st_arb_pkg.sv
// ---------------------------------------------------------------------------
// avalon_st_arb_pkg
// Shared types and helpers for the packet-atomic Avalon-ST arbiter.
//   arb_state_t : arbiter FSM state (IDLE = arbitrating, PKT = packet owned)
//   rr_pick     : round-robin search over a request vector
// ---------------------------------------------------------------------------
package avalon_st_arb_pkg;

  // Upper bound on the number of arbitrated inputs.
  localparam int MAX_IN = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_t;

  // First asserted request searching ptr, ptr+1, ... modulo n.
  // Returns ptr unchanged when nothing is requesting.
  function automatic logic [3:0] rr_pick(input logic [MAX_IN-1:0] req,
                                         input logic [3:0]        ptr,
                                         input int                n);
    int   idx;
    logic found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < MAX_IN; k++) begin
      idx = (int'(ptr) + k) % n;
      if ((k < n) && !found && req[idx[3:0]]) begin
        rr_pick = idx[3:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// ---------------------------------------------------------------------------
// avalon_st_if
// Avalon-ST stream bundle. All streams run on the arbiter clock.
//   src  modport : drives valid/data/sop/eop/empty/channel, receives ready
//   sink modport : receives valid/data/sop/eop/empty/channel, drives ready
// ---------------------------------------------------------------------------
interface avalon_st_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int CHANNEL_WIDTH = 2,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8)
);
  logic                     valid;
  logic                     ready;
  logic [DATA_WIDTH-1:0]    data;
  logic                     startofpacket;
  logic                     endofpacket;
  logic [EMPTY_WIDTH-1:0]   empty;
  logic [CHANNEL_WIDTH-1:0] channel;

  modport src  (output valid, data, startofpacket, endofpacket, empty, channel,
                input  ready);
  modport sink (input  valid, data, startofpacket, endofpacket, empty, channel,
                output ready);
endinterface

// File: rtl/avalon_st_out_reg.sv
// ---------------------------------------------------------------------------
// avalon_st_out_reg
// Single-entry registered Avalon-ST stage with valid/ready handshake.
//   clk, rst        : clock, asynchronous active-high reset
//   in_*_i          : upstream beat (valid, data, sop, eop, empty, channel)
//   in_ready_o      : stage can take a beat this cycle
//   out_*_o         : registered beat presented downstream
//   out_ready_i     : downstream accepts the presented beat
// ---------------------------------------------------------------------------
module avalon_st_out_reg #(
  parameter int DATA_WIDTH    = 32,
  parameter int CHANNEL_WIDTH = 2,
  parameter int EMPTY_WIDTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_WIDTH-1:0]    in_data_i,
  input  logic                     in_sop_i,
  input  logic                     in_eop_i,
  input  logic [EMPTY_WIDTH-1:0]   in_empty_i,
  input  logic [CHANNEL_WIDTH-1:0] in_channel_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_WIDTH-1:0]    out_data_o,
  output logic                     out_sop_o,
  output logic                     out_eop_o,
  output logic [EMPTY_WIDTH-1:0]   out_empty_o,
  output logic [CHANNEL_WIDTH-1:0] out_channel_o
);

  logic                     valid_q, valid_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     sop_q, sop_d;
  logic                     eop_q, eop_d;
  logic [EMPTY_WIDTH-1:0]   empty_q, empty_d;
  logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;

  // Ready depends only on local occupancy and downstream ready, never on
  // in_valid_i, so no combinational valid->ready path exists.
  assign in_ready_o = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    empty_d = empty_q;
    chan_d  = chan_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
      sop_d   = in_sop_i;
      eop_d   = in_eop_i;
      empty_d = in_empty_i;
      chan_d  = in_channel_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
      chan_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      empty_q <= empty_d;
      chan_q  <= chan_d;
    end
  end

  assign out_valid_o   = valid_q;
  assign out_data_o    = data_q;
  assign out_sop_o     = sop_q;
  assign out_eop_o     = eop_q;
  assign out_empty_o   = empty_q;
  assign out_channel_o = chan_q;

endmodule

// File: rtl/avalon_st_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_st_pkt_arbiter
// Packet-atomic round-robin merge of N_IN Avalon-ST sources onto one sink.
// A grant is held from the first accepted beat until its endofpacket beat is
// accepted; arbitration costs one idle cycle between packets.
//   clk, rst     : clock, asynchronous active-high reset
//   sink_if[]    : input streams (avalon_st_if.sink)
//   src_if       : merged, registered output stream (avalon_st_if.src)
//   grant_idx_o  : current or last granted input index
//   busy_o       : high while a packet owns the output (state PKT)
// ---------------------------------------------------------------------------
module avalon_st_pkt_arbiter
  import avalon_st_arb_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int CHANNEL_WIDTH = 2,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int TAG_CHANNEL   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  avalon_st_if.sink               sink_if [N_IN],
  avalon_st_if.src                src_if,
  output logic [$clog2(N_IN)-1:0] grant_idx_o,
  output logic                    busy_o
);

  localparam int GW = $clog2(N_IN);

  // Flatten the interface array so the granted stream can be selected with a
  // run-time index.
  logic [N_IN-1:0]          req;
  logic [N_IN-1:0]          sop_a;
  logic [N_IN-1:0]          eop_a;
  logic [DATA_WIDTH-1:0]    data_a  [N_IN];
  logic [EMPTY_WIDTH-1:0]   empty_a [N_IN];
  logic [CHANNEL_WIDTH-1:0] chan_a  [N_IN];
  logic [N_IN-1:0]          sink_rdy;

  for (genvar i = 0; i < N_IN; i++) begin : g_sink
    assign req[i]           = sink_if[i].valid;
    assign sop_a[i]         = sink_if[i].startofpacket;
    assign eop_a[i]         = sink_if[i].endofpacket;
    assign data_a[i]        = sink_if[i].data;
    assign empty_a[i]       = sink_if[i].empty;
    assign chan_a[i]        = sink_if[i].channel;
    assign sink_if[i].ready = sink_rdy[i];
  end

  arb_state_t      state_q, state_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [GW-1:0]   pick;
  logic            stage_rdy;
  logic            in_vld;
  logic            accept;
  logic [CHANNEL_WIDTH-1:0] chan_sel;

  assign pick = GW'(rr_pick(MAX_IN'(req), 4'(rr_ptr_q), N_IN));

  if (TAG_CHANNEL != 0) begin : g_tag
    assign chan_sel = CHANNEL_WIDTH'(grant_q);
  end else begin : g_pass
    assign chan_sel = chan_a[grant_q];
  end

  always_comb begin
    in_vld   = (state_q == PKT) && req[grant_q];
    accept   = in_vld && stage_rdy;
    sink_rdy = '0;
    // Only the granted input ever sees ready, and only while a packet is owned.
    if (state_q == PKT) sink_rdy[grant_q] = stage_rdy;

    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick;
          state_d = PKT;
        end
      end
      PKT: begin
        // Release only on an accepted eop; a stalled granted source keeps it.
        if (accept && eop_a[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == GW'(N_IN - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == PKT);
  end

  // ---- arbitration state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
    end
  end

  assign grant_idx_o = grant_q;
  assign busy_o      = busy_q;

  avalon_st_out_reg #(
    .DATA_WIDTH    (DATA_WIDTH),
    .CHANNEL_WIDTH (CHANNEL_WIDTH),
    .EMPTY_WIDTH   (EMPTY_WIDTH)
  ) u_out (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_vld),
    .in_ready_o    (stage_rdy),
    .in_data_i     (data_a[grant_q]),
    .in_sop_i      (sop_a[grant_q]),
    .in_eop_i      (eop_a[grant_q]),
    .in_empty_i    (empty_a[grant_q]),
    .in_channel_i  (chan_sel),
    .out_valid_o   (src_if.valid),
    .out_ready_i   (src_if.ready),
    .out_data_o    (src_if.data),
    .out_sop_o     (src_if.startofpacket),
    .out_eop_o     (src_if.endofpacket),
    .out_empty_o   (src_if.empty),
    .out_channel_o (src_if.channel)
  );

endmodule
